hdmi_tmds_align: RTL
====================

# hdmi_tmds_align

Per-channel TMDS word aligner and 10b/8b decoder for the HDMI receive path. It consumes the raw 10-bit words produced by the HDMI input deserializer, whose bit framing is arbitrary. It searches the ten possible bit rotations for the HDMI control tokens sent during blanking, then locks on one rotation and decodes each aligned symbol into pixel data, control bits and data-enable. Downstream channel-deskew and video-timing logic consume its outputs.

## Interface
- SYNC_COUNT, 16: consecutive control tokens required at one rotation to declare lock.
- SEARCH_WINDOW, 4096: qualified words examined per rotation before moving to the next rotation.
- LOCK_TIMEOUT, 4096: qualified words allowed without any control token before lock is dropped.

- i_clk  input  1  pixel clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_ce  input  1  qualifies i_word. All registers advance only when i_ce=1.
- i_word  input  10  raw deserialized word. Bit 0 is the earliest received bit.
- i_realign  input  1  one-cycle request to abandon the current rotation. Sampled only with i_ce.
- o_locked  output  1  alignment locked.
- o_shift  output  4  current rotation, 0..9.
- o_de  output  1  1 = data symbol, 0 = control symbol.
- o_ctl  output  2  decoded control bits {C1,C0}. Holds its last value while o_de=1.
- o_data  output  8  decoded pixel byte. Holds its last value while o_de=0.

## Operation
- History register prev captures i_word on each i_ce. combined = {i_word, prev} (20 bits, chronological by bit index).
- Aligned word = combined[s+9:s], where s is the current rotation. The aligned word is registered on each i_ce.
- Token detect uses the aligned register. Control tokens are 10'h354 (C=00), 10'h0AB (01), 10'h154 (10) and 10'h2AB (11). Any other value is a data symbol; TERC4 and guard bands are also treated as data.
- Decode of a data symbol w:
  - q = w[9] ? ~w[7:0] : w[7:0].
  - d[0] = q[0].
  - For i=1..7: d[i] = w[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- State machine, with states SEARCH and LOCKED. Reset enters SEARCH with s=0.
- SEARCH:
  - tok_cnt increments on each token word and clears on each non-token word.
  - win_cnt increments on every qualified word.
  - When tok_cnt reaches SYNC_COUNT, go to LOCKED and clear both counters.
  - Otherwise, when win_cnt reaches SEARCH_WINDOW-1, set s = (s==9) ? 0 : s+1 and clear tok_cnt and win_cnt.
  - If a token completes SYNC_COUNT on the same word that win_cnt expires, lock wins and s is unchanged.
- LOCKED:
  - to_cnt clears on any token word and otherwise increments.
  - When to_cnt reaches LOCK_TIMEOUT-1, go to SEARCH with s unchanged and all counters cleared.
- i_realign (with i_ce), from either state: enter SEARCH, advance s with wrap 9→0, and clear all counters. It has priority over lock and timeout on the same cycle.
- Counter widths are $clog2 of their parameter plus 1. Counters saturate rather than wrap.
- o_de, o_ctl and o_data update in both states; they are only meaningful while o_locked=1.
- On reset: o_locked=0, o_shift=0, o_de=0, o_ctl=0, o_data=0, prev=0, aligned=0, and all counters 0. An async reset mid-search or mid-lock returns to these values immediately.

## Timing
- Decode latency: an i_word bit appears in the aligned register on the next qualified edge, and its decoded outputs appear one further qualified edge later.
  - With s=0, the aligned word is the previous i_word, so total latency is 3 qualified words from i_word to o_data.
  - With s>0, the aligned word straddles the previous and current i_word; total latency is 2 qualified words, counted from the later of the two contributing words.
- o_locked rises on the qualified edge after the SYNC_COUNT-th consecutive token is in the aligned register. It falls on the edge that processes the timeout or realign event.
- o_shift changes on the same edge as s. The aligned output under the new rotation is valid one qualified word later, and the counters ignore that first word.
- When i_ce=0, all state and outputs hold.

## Test plan
- Reset: hold i_reset_n=0 while driving random words → every output is 0. Release reset → state is SEARCH with o_shift=0.
- Lock at rotation 3: feed 10'h354 repeatedly, rotated by 3 bits across word boundaries. The leading non-token words must span one full SEARCH_WINDOW at each of rotations 0..2 → o_shift steps 0→1→2→3, and o_locked=1 after 16 tokens at s=3 with o_ctl=00 and o_de=0.
- Decode: while locked at s=0, feed 10'h100, 10'h0FF, 10'h2AB → o_data=8'h00 (o_de=1), then o_data=8'hFF (o_de=1), then o_ctl=11 (o_de=0), each with the stated latency.
- Timeout: while locked, feed 4096 consecutive data words → o_locked drops on the 4096th word and o_shift is unchanged. Resuming tokens relocks after 16 tokens.
- Wrap and realign: at s=9, pulse i_realign → o_shift=0 and o_locked=0. Pulse i_realign on the same cycle as the 16th token → no lock, and s advances.
- Mid-operation reset: assert i_reset_n=0 while locked at s=7 → o_locked=0 and o_shift=0 asynchronously, and the search restarts from rotation 0.

Source files
------------

// File: rtl/hdmi_tmds_align.sv
// Per-channel TMDS word aligner and 10b/8b decoder: hunts the ten bit rotations for
// control tokens, locks on one rotation, and decodes aligned symbols.
`timescale 1ns/1ps
module hdmi_tmds_align #(
    parameter int unsigned SYNC_COUNT    = 16,
    parameter int unsigned SEARCH_WINDOW = 4096,
    parameter int unsigned LOCK_TIMEOUT  = 4096
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic [9:0] i_word,
    input  logic       i_realign,
    output logic       o_locked,
    output logic [3:0] o_shift,
    output logic       o_de,
    output logic [1:0] o_ctl,
    output logic [7:0] o_data
);

    localparam int unsigned TokW = $clog2(SYNC_COUNT) + 1;
    localparam int unsigned WinW = $clog2(SEARCH_WINDOW) + 1;
    localparam int unsigned ToW  = $clog2(LOCK_TIMEOUT) + 1;

    typedef enum logic {StSearch, StLocked} state_e;

    state_e            state_q, state_d;
    logic [3:0]        shift_q, shift_d;
    logic              skip_q, skip_d;
    logic [TokW-1:0]   tok_cnt_q, tok_cnt_d;
    logic [WinW-1:0]   win_cnt_q, win_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [9:0]        prev_q, aligned_q;
    logic              de_q;
    logic [1:0]        ctl_q;
    logic [7:0]        data_q;

    logic [19:0]       combined;
    logic              is_tok;
    logic [1:0]        tok_ctl;
    logic [7:0]        q_bits, dec;
    logic [TokW-1:0]   tok_inc;
    logic [WinW-1:0]   win_inc;
    logic [ToW-1:0]    to_inc;
    logic [3:0]        shift_next;

    assign combined   = {i_word, prev_q};
    assign shift_next = (shift_q == 4'd9) ? 4'd0 : shift_q + 4'd1;
    assign tok_inc    = (&tok_cnt_q) ? tok_cnt_q : tok_cnt_q + 1'b1;
    assign win_inc    = (&win_cnt_q) ? win_cnt_q : win_cnt_q + 1'b1;
    assign to_inc     = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 1'b1;

    always_comb begin
        is_tok  = 1'b1;
        tok_ctl = 2'b00;
        case (aligned_q)
            10'h354: tok_ctl = 2'b00;
            10'h0AB: tok_ctl = 2'b01;
            10'h154: tok_ctl = 2'b10;
            10'h2AB: tok_ctl = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // Transition-minimised data decode: undo optional inversion, then XOR/XNOR chain.
    always_comb begin
        q_bits = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
        dec    = 8'h00;
        dec[0] = q_bits[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = aligned_q[8] ? (q_bits[i] ^ q_bits[i-1]) : ~(q_bits[i] ^ q_bits[i-1]);
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        skip_d    = skip_q;
        tok_cnt_d = tok_cnt_q;
        win_cnt_d = win_cnt_q;
        to_cnt_d  = to_cnt_q;
        if (i_ce) begin
            skip_d = 1'b0;
            if (i_realign) begin
                state_d   = StSearch;
                shift_d   = shift_next;
                skip_d    = 1'b1;
                tok_cnt_d = '0;
                win_cnt_d = '0;
                to_cnt_d  = '0;
            end else if (!skip_q) begin
                // The first word after a rotation change was sampled under the old rotation.
                unique case (state_q)
                    StSearch: begin
                        tok_cnt_d = is_tok ? tok_inc : '0;
                        win_cnt_d = win_inc;
                        if (is_tok && tok_inc == TokW'(SYNC_COUNT)) begin
                            state_d   = StLocked;
                            tok_cnt_d = '0;
                            win_cnt_d = '0;
                            to_cnt_d  = '0;
                        end else if (win_cnt_q == WinW'(SEARCH_WINDOW - 1)) begin
                            shift_d   = shift_next;
                            skip_d    = 1'b1;
                            tok_cnt_d = '0;
                            win_cnt_d = '0;
                        end
                    end
                    StLocked: begin
                        if (is_tok) begin
                            to_cnt_d = '0;
                        end else if (to_cnt_q == ToW'(LOCK_TIMEOUT - 1)) begin
                            state_d   = StSearch;
                            tok_cnt_d = '0;
                            win_cnt_d = '0;
                            to_cnt_d  = '0;
                        end else begin
                            to_cnt_d = to_inc;
                        end
                    end
                    default: state_d = StSearch;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= StSearch;
            shift_q   <= 4'd0;
            skip_q    <= 1'b0;
            tok_cnt_q <= '0;
            win_cnt_q <= '0;
            to_cnt_q  <= '0;
            prev_q    <= 10'd0;
            aligned_q <= 10'd0;
            de_q      <= 1'b0;
            ctl_q     <= 2'b00;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            skip_q    <= skip_d;
            tok_cnt_q <= tok_cnt_d;
            win_cnt_q <= win_cnt_d;
            to_cnt_q  <= to_cnt_d;
            if (i_ce) begin
                prev_q    <= i_word;
                aligned_q <= combined[shift_q +: 10];
                if (is_tok) begin
                    de_q  <= 1'b0;
                    ctl_q <= tok_ctl;
                end else begin
                    de_q   <= 1'b1;
                    data_q <= dec;
                end
            end
        end
    end

    assign o_locked = (state_q == StLocked);
    assign o_shift  = shift_q;
    assign o_de     = de_q;
    assign o_ctl    = ctl_q;
    assign o_data   = data_q;

endmodule
